stream_flow_ctrl: RTL
=====================

Name: stream_flow_ctrl

Overview:
Sequences the ADC → input FIFO → Costas loop → output FIFO → DAC streaming path. It gates the input-FIFO write, the DSP/FIFO-transfer enable and the DAC-side read. It waits for clocks and FIFO resets to settle, then pre-fills the output FIFO, then streams. It counts overflow and underflow events for the ILA.

Parameters:
SETTLE_CYCLES, 16, consecutive ready cycles required in WAIT_RDY before leaving it (≥1)
CNT_WIDTH, 16, width of the saturating event counters

Ports:
clk  in  1  system clock (clk_wiz_0 clk_out1)
rst  in  1  synchronous active-high reset
run_req  in  1  streaming request (debounced switch/host); level-sensitive
clk_locked  in  1  system MMCM locked
adc_locked  in  1  ADC capture clock locked
in_wr_rst_busy  in  1  input FIFO write-side reset busy
in_rd_rst_busy  in  1  input FIFO read-side reset busy
in_almst_empty  in  1  input FIFO almost_empty
in_almst_full  in  1  input FIFO almost_full
out_almst_empty  in  1  output FIFO almost_empty
out_almst_full  in  1  output FIFO almost_full
in_wr_en  out  1  input FIFO write enable (ANDed externally with the sample valid)
dsp_en  out  1  input FIFO rd_en, Costas enable, output FIFO wr_en
dac_rd_en  out  1  output FIFO rd_en towards interpolation/DAC
running  out  1  high in RUN
state  out  2  current state: IDLE=0, WAIT_RDY=1, FILL=2, RUN=3
ovf_cnt  out  CNT_WIDTH  input overflow events, saturating
udf_cnt  out  CNT_WIDTH  output underflow events, saturating

Behaviour:
- All outputs are registered; each output reflects the inputs sampled on the previous edge (latency 1). The almost flags provide the margin for this lag.
- Reset: state=IDLE; all enables and running are 0; settle counter, ovf_cnt and udf_cnt are 0.
- ready = clk_locked & adc_locked & !in_wr_rst_busy & !in_rd_rst_busy.
- IDLE: all enables 0. If run_req=1, go to WAIT_RDY and clear the settle counter.
- WAIT_RDY: all enables 0.
  - Settle counter increments while ready=1 and clears when ready=0.
  - When it reaches SETTLE_CYCLES-1 with ready=1, go to FILL.
- FILL:
  - in_wr_en = !in_almst_full.
  - dsp_en = !in_almst_empty & !out_almst_full.
  - dac_rd_en = 0.
  - When out_almst_empty=0, go to RUN.
- RUN:
  - in_wr_en and dsp_en behave as in FILL.
  - dac_rd_en = !out_almst_empty.
  - If out_almst_empty=1: go to FILL, udf_cnt +1, dac_rd_en=0 that cycle.
- Overflow: in FILL or RUN, each cycle with in_almst_full=1 while the state would otherwise write increments ovf_cnt. The sample is dropped (in_wr_en=0).
- Exit paths:
  - run_req=0 in any non-IDLE state → IDLE next cycle; all enables drop. This has priority over every other transition.
  - ready=0 in FILL or RUN → WAIT_RDY; enables drop; counters are kept.
- Event counters saturate at 2^CNT_WIDTH-1 and never wrap. They are cleared only by rst.
- Simultaneous events: an underflow and an overflow in the same cycle both increment. The run_req=0 transition suppresses the underflow increment.
- rst asserted mid-stream returns everything to reset values on the next edge, regardless of state.
- Encoding is binary; illegal encodings are impossible (2-bit, all 4 used).

Decomposition:
- Shared package stream_pkg holds:
  - state localparams ST_IDLE/ST_WAIT_RDY/ST_FILL/ST_RUN
  - a default CNT_WIDTH constant
  - a default SETTLE_CYCLES constant
- One sub-module, sat_counter (parameter WIDTH; inputs clk, rst, inc; output q), instantiated twice for ovf_cnt/udf_cnt.
- The FSM and enable logic stay in the top module.

Test Plan:
1. Startup, SETTLE_CYCLES=16: rst pulse, all ready inputs high, run_req=1 → state=1 for 16 cycles, then state=2. in_wr_en=1, dac_rd_en=0.
2. Pre-fill: in FILL, drop out_almst_empty 1→0 → state=3 one cycle later; dac_rd_en=1 the cycle after; running=1.
3. Underflow: in RUN, raise out_almst_empty for 1 cycle → state=2, dac_rd_en=0, udf_cnt=1. Clearing it returns to RUN.
4. Overflow saturation, CNT_WIDTH=4: hold in_almst_full=1 for 20 cycles in RUN → in_wr_en=0 throughout, ovf_cnt stops at 15.
5. Lock loss and stop: clk_locked=0 in RUN → state=1, all enables 0, counters unchanged. Then run_req=0 → state=0.
6. Settle glitch: in WAIT_RDY, pulse in_rd_rst_busy high at count 10 → counter restarts; FILL is entered 16 cycles after the glitch clears.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared types and defaults for the ADC -> FIFO -> Costas -> FIFO -> DAC stream sequencer.
package stream_pkg;

  // Binary state encoding; the value is exported on the state port for the ILA.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RDY = 2'd1,
    ST_FILL     = 2'd2,
    ST_RUN      = 2'd3
  } state_e;

  localparam int unsigned DEF_CNT_WIDTH     = 16;
  localparam int unsigned DEF_SETTLE_CYCLES = 16;

endpackage

// File: rtl/stream_flow_ctrl_if.sv
// FIFO-side flags and enables of the streaming path, grouped as one bundle.
interface stream_flow_ctrl_if;
  logic in_wr_rst_busy;
  logic in_rd_rst_busy;
  logic in_almst_empty;
  logic in_almst_full;
  logic out_almst_empty;
  logic out_almst_full;
  logic in_wr_en;
  logic dsp_en;
  logic dac_rd_en;

  // Controller side: reads FIFO status, drives the enables.
  modport master (
    input  in_wr_rst_busy, in_rd_rst_busy, in_almst_empty, in_almst_full,
    input  out_almst_empty, out_almst_full,
    output in_wr_en, dsp_en, dac_rd_en
  );

  // FIFO side: drives status, consumes the enables.
  modport slave (
    output in_wr_rst_busy, in_rd_rst_busy, in_almst_empty, in_almst_full,
    output out_almst_empty, out_almst_full,
    input  in_wr_en, dsp_en, dac_rd_en
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones, cleared only by rst.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  // Increment unless already saturated.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/stream_flow_ctrl.sv
// Sequences the streaming path: wait for clocks/FIFO resets, pre-fill the output FIFO, stream.
// All outputs are registered and reflect the inputs sampled on the previous edge.
module stream_flow_ctrl
  import stream_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_req,
  input  logic                 clk_locked,
  input  logic                 adc_locked,
  stream_flow_ctrl_if.master   fifo,
  output logic                 running,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] ovf_cnt,
  output logic [CNT_WIDTH-1:0] udf_cnt
);

  localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  state_e              state_q;
  logic [SETTLE_W-1:0] settle_q;
  logic                in_wr_en_q;
  logic                dsp_en_q;
  logic                dac_rd_en_q;
  logic                running_q;

  logic ready;
  logic streaming;
  logic ovf_inc;
  logic udf_inc;

  assign ready = clk_locked & adc_locked & ~fifo.in_wr_rst_busy & ~fifo.in_rd_rst_busy;

  // FILL/RUN that will keep moving data this cycle (no stop, no lock loss).
  assign streaming = run_req & ready & ((state_q == ST_FILL) | (state_q == ST_RUN));

  // A sample is dropped whenever the write would have happened but the input FIFO is full.
  assign ovf_inc = streaming & fifo.in_almst_full;

  // Underflow still counts on a lock loss; only a stop request suppresses it.
  assign udf_inc = run_req & (state_q == ST_RUN) & fifo.out_almst_empty;

  // State machine with registered enables; stop request overrides every other transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      settle_q    <= '0;
      in_wr_en_q  <= 1'b0;
      dsp_en_q    <= 1'b0;
      dac_rd_en_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      in_wr_en_q  <= 1'b0;
      dsp_en_q    <= 1'b0;
      dac_rd_en_q <= 1'b0;
      running_q   <= 1'b0;
      if ((state_q != ST_IDLE) && !run_req) begin
        state_q  <= ST_IDLE;
        settle_q <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (run_req) begin
              state_q  <= ST_WAIT_RDY;
              settle_q <= '0;
            end
          end
          ST_WAIT_RDY: begin
            if (!ready) begin
              settle_q <= '0;
            end else if (settle_q == SETTLE_LAST) begin
              state_q  <= ST_FILL;
              settle_q <= '0;
            end else begin
              settle_q <= settle_q + SETTLE_W'(1);
            end
          end
          ST_FILL, ST_RUN: begin
            if (!ready) begin
              state_q  <= ST_WAIT_RDY;
              settle_q <= '0;
            end else begin
              in_wr_en_q <= ~fifo.in_almst_full;
              dsp_en_q   <= ~fifo.in_almst_empty & ~fifo.out_almst_full;
              if (state_q == ST_FILL) begin
                if (!fifo.out_almst_empty) begin
                  state_q   <= ST_RUN;
                  running_q <= 1'b1;
                end
              end else if (fifo.out_almst_empty) begin
                // Output FIFO drained: stop reading and re-fill.
                state_q <= ST_FILL;
              end else begin
                dac_rd_en_q <= 1'b1;
                running_q   <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_ovf_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ovf_inc),
    .q   (ovf_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_udf_cnt (
    .clk (clk),
    .rst (rst),
    .inc (udf_inc),
    .q   (udf_cnt)
  );

  assign fifo.in_wr_en  = in_wr_en_q;
  assign fifo.dsp_en    = dsp_en_q;
  assign fifo.dac_rd_en = dac_rd_en_q;
  assign running        = running_q;
  assign state          = state_q;

endmodule
